// File: rtl/fetch_pkg.sv
// Shared types for the decoupled instruction-fetch stage.
// The fetch-queue entry carries PC, instruction word and fault flags.
package fetch_pkg;

    localparam int FQ_XLEN     = 64;
    localparam int FQ_ILEN     = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_ILEN-1:0] instr;
        logic               misaligned;
        logic               acc_fault;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Pointer-based FIFO with flush; an extra pointer bit separates full from empty.
// Push and pop in the same cycle are legal at any occupancy, including full.
module fetch_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  T                       push_data,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_pop;

    assign count  = wptr - rptr;
    assign full   = count == (AW+1)'(DEPTH);
    assign empty  = wptr == rptr;
    assign do_pop = pop && !empty;
    assign head   = mem[rptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: reads are qualified by empty.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[wptr[AW-1:0]] <= push_data;
        end
    end

    a_no_overflow: assert property (
        @(posedge clock) disable iff (reset)
        !(push && !flush && full && !pop)
    );

endmodule

// File: rtl/stage_if_fq.sv
// Decoupled IF stage: sequential PC, credit-limited bus issue, in-order
// response queue, stale-response dropping after redirect, halt on faults.
module stage_if_fq
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FQ_XLEN,
    parameter int              ILEN     = FQ_ILEN,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_fence_i,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    output logic            req_fence_i,
    input  logic            resp_valid,
    input  logic [ILEN-1:0] resp_rdata,
    input  logic            resp_acc_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
    output logic            out_misaligned,
    output logic            out_acc_fault
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   out_nxt;
    logic [OW-1:0]   drop;
    logic            halted;
    logic            fence_pend;

    logic            misal;
    logic            credit;
    logic            fire;
    logic            resp_keep;
    logic            misal_push;
    logic            push;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    fq_entry_t       push_data;
    fq_entry_t       head;

    fetch_fifo #(
        .T     (fq_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .pop       (out_ready),
        .push_data (push_data),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        misal  = fetch_pc[1:0] != 2'b00;
        credit = (int'(count) + int'(outstanding)) < DEPTH;
        req_valid = !reset && !halted && !redirect_valid && !misal
                 && (int'(outstanding) < MAX_OUT) && credit;
        fire       = req_valid && req_ready;
        resp_keep  = resp_valid && (drop == '0);
        misal_push = !reset && !halted && !redirect_valid && misal
                  && (outstanding == '0) && !full;
        push       = !redirect_valid && (resp_keep || misal_push);
        out_nxt    = outstanding + OW'(fire) - OW'(resp_valid);
    end

    always_comb begin
        push_data = '0;
        unique case (1'b1)
            misal_push: begin
                push_data.pc         = fetch_pc;
                push_data.misaligned = 1'b1;
            end
            default: begin
                push_data.pc        = resp_pc;
                push_data.instr     = resp_acc_err ? '0 : resp_rdata;
                push_data.acc_fault = resp_acc_err;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            halted      <= 1'b0;
            fence_pend  <= 1'b0;
        end else begin
            outstanding <= out_nxt;
            if (redirect_valid) begin
                fetch_pc   <= redirect_pc;
                resp_pc    <= redirect_pc;
                drop       <= out_nxt;
                halted     <= 1'b0;
                fence_pend <= redirect_fence_i;
            end else begin
                if (fire) begin
                    fetch_pc   <= fetch_pc + XLEN'(INSTR_BYTES);
                    fence_pend <= 1'b0;
                end
                if (resp_valid && drop != '0) begin
                    drop <= drop - 1'b1;
                end
                // A faulted response halts and drops the rest of its stream.
                if (resp_keep) begin
                    resp_pc <= resp_pc + XLEN'(INSTR_BYTES);
                    if (resp_acc_err) begin
                        halted <= 1'b1;
                        drop   <= out_nxt;
                    end
                end
                if (misal_push) begin
                    halted <= 1'b1;
                end
            end
        end
    end

    assign req_addr       = req_valid ? fetch_pc : '0;
    assign req_fence_i    = fence_pend;
    assign out_valid      = !empty;
    assign out_pc         = empty ? '0 : head.pc;
    assign out_instr      = empty ? '0 : head.instr;
    assign out_misaligned = !empty && head.misaligned;
    assign out_acc_fault  = !empty && head.acc_fault;

endmodule
